d_ip_timer_count_reg: RTL and testbench

Programmable timer counter register bank for the timer IP. It holds the live count `value` plus its control, load and compare registers behind a simple single-cycle register port. It produces the compare-match status flag and the interrupt. It is the driving end of the `value` bus that the reset-value assertion checker observes, so `value` reads exactly `RST_VAL` on the first clock after reset is released.

---
 rtl/d_ip_timer_count_reg.sv | 181 ++++++++++++++++++
 tb/tb_d_ip_timer_count_reg.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/d_ip_timer_count_reg.sv
// Purpose : timer IP register bank - live counter with prescaler, load/compare/ctrl
//           registers, compare-match status flag and level interrupt.
// Latency : register writes visible next cycle; rd_data valid 1 cycle after rd_en;
//           irq combinational from MATCH & IE.
// Backpressure: none - single-cycle register port, every strobe is accepted.
//
// Ports:
//   clk, rst            single clock, asynchronous active-high reset
//   wr_en/wr_addr/wr_data  register write (0 CTRL, 1 LOAD, 2 COMPARE, 3 STATUS)
//   rd_en/rd_addr/rd_data  registered read, same map; rd_data holds when idle
//   value               live counter value (not address-mapped)
//   irq                 level interrupt
//
// Build option: define D_IP_TIMER_IRQ_EN to implement CTRL.IE and drive irq;
// without it irq is tied low and CTRL bit2 reads 0 (polling only).
//
// PRESC_W must be <= 8 since the prescaler lives in CTRL[15:8]; SIZE >= 16.

module d_ip_timer_count_reg #(
    parameter int unsigned     SIZE    = 32,
    parameter logic [SIZE-1:0] RST_VAL = '0,
    parameter int unsigned     PRESC_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wr_en,
    input  logic [1:0]      wr_addr,
    input  logic [SIZE-1:0] wr_data,
    input  logic            rd_en,
    input  logic [1:0]      rd_addr,
    output logic [SIZE-1:0] rd_data,
    output logic [SIZE-1:0] value,
    output logic            irq
);

    localparam logic [1:0] ADDR_CTRL    = 2'd0;
    localparam logic [1:0] ADDR_LOAD    = 2'd1;
    localparam logic [1:0] ADDR_COMPARE = 2'd2;
    localparam logic [1:0] ADDR_STATUS  = 2'd3;

    localparam logic [PRESC_W-1:0] PRESC_ONE = 1;
    localparam logic [SIZE-1:0]    SIZE_ONE  = 1;

    // Control fields
    logic               r_en;
    logic               r_ar;
    logic [PRESC_W-1:0] r_presc;
`ifdef D_IP_TIMER_IRQ_EN
    logic               r_ie;
`endif

    logic [PRESC_W-1:0] r_presc_cnt;
    logic [SIZE-1:0]    r_load;
    logic [SIZE-1:0]    r_compare;
    logic [SIZE-1:0]    r_value;
    logic               r_match;
    logic [SIZE-1:0]    r_rd_data;

    logic               w_tick;
    logic               w_hit;
    logic               w_wr_ctrl;
    logic               w_wr_load;
    logic               w_wr_compare;
    logic               w_w1c;
    logic [SIZE-1:0]    w_ctrl_rd;
    logic [SIZE-1:0]    w_rd_mux;

    // Tick and match are always evaluated on the pre-write register contents,
    // so same-cycle writes to COMPARE or LOAD never alter this cycle's check.
    always_comb begin
        w_tick       = r_en && (r_presc_cnt == r_presc);
        w_hit        = w_tick && (r_value == r_compare);
        w_wr_ctrl    = wr_en && (wr_addr == ADDR_CTRL);
        w_wr_load    = wr_en && (wr_addr == ADDR_LOAD);
        w_wr_compare = wr_en && (wr_addr == ADDR_COMPARE);
        w_w1c        = wr_en && (wr_addr == ADDR_STATUS) && wr_data[0];
    end

    // CTRL read-back: unimplemented bits read 0
    always_comb begin
        w_ctrl_rd                 = '0;
        w_ctrl_rd[0]              = r_en;
        w_ctrl_rd[1]              = r_ar;
`ifdef D_IP_TIMER_IRQ_EN
        w_ctrl_rd[2]              = r_ie;
`endif
        w_ctrl_rd[8 +: PRESC_W]   = r_presc;
    end

    always_comb begin
        w_rd_mux = '0;
        case (rd_addr)
            ADDR_CTRL:    w_rd_mux = w_ctrl_rd;
            ADDR_LOAD:    w_rd_mux = r_load;
            ADDR_COMPARE: w_rd_mux = r_compare;
            ADDR_STATUS:  w_rd_mux[0] = r_match;
            default:      w_rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_en    <= 1'b0;
            r_ar    <= 1'b0;
            r_presc <= '0;
`ifdef D_IP_TIMER_IRQ_EN
            r_ie    <= 1'b0;
`endif
        end else if (w_wr_ctrl) begin
            r_en    <= wr_data[0];
            r_ar    <= wr_data[1];
            r_presc <= wr_data[8 +: PRESC_W];
`ifdef D_IP_TIMER_IRQ_EN
            r_ie    <= wr_data[2];
`endif
        end
    end

    // Prescaler restarts on any CTRL write so a new PRESC/EN always begins
    // a full period from the write edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_presc_cnt <= '0;
        end else if (w_wr_ctrl || !r_en || w_tick) begin
            r_presc_cnt <= '0;
        end else begin
            r_presc_cnt <= r_presc_cnt + PRESC_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_load    <= '0;
            r_compare <= '0;
        end else begin
            if (w_wr_load)    r_load    <= wr_data;
            if (w_wr_compare) r_compare <= wr_data;
        end
    end

    // A LOAD write overrides whatever the tick would have done this edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_value <= RST_VAL;
        end else if (w_wr_load) begin
            r_value <= wr_data;
        end else if (w_tick) begin
            if (w_hit && r_ar) r_value <= r_load;
            else               r_value <= r_value + SIZE_ONE;
        end
    end

    // Set has priority over write-1-to-clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_match <= 1'b0;
        end else if (w_hit) begin
            r_match <= 1'b1;
        end else if (w_w1c) begin
            r_match <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_data <= '0;
        end else if (rd_en) begin
            r_rd_data <= w_rd_mux;
        end
    end

    assign rd_data = r_rd_data;
    assign value   = r_value;

`ifdef D_IP_TIMER_IRQ_EN
    assign irq = r_match & r_ie;
`else
    assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_d_ip_timer_count_reg.sv
// Scoreboard bench for d_ip_timer_count_reg: a driver applies directed and
// random register traffic and pushes the reference model's expected post-edge
// outputs into a queue; an independent monitor pops and compares each cycle.

module tb_d_ip_timer_count_reg;

    localparam logic [31:0] RST_VAL = 32'h0;
`ifdef D_IP_TIMER_IRQ_EN
    localparam logic [31:0] CTRL_MASK = 32'h0000_FF07;
`else
    localparam logic [31:0] CTRL_MASK = 32'h0000_FF03;
`endif

    logic        clk     = 1'b0;
    logic        rst     = 1'b1;
    logic        wr_en   = 1'b0;
    logic [1:0]  wr_addr = 2'd0;
    logic [31:0] wr_data = 32'h0;
    logic        rd_en   = 1'b0;
    logic [1:0]  rd_addr = 2'd0;
    logic [31:0] rd_data;
    logic [31:0] value;
    logic        irq;

    d_ip_timer_count_reg #(
        .SIZE    (32),
        .RST_VAL (RST_VAL),
        .PRESC_W (8)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .value   (value),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] v;
        logic        irq;
        logic [31:0] rd;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    bit   rst_next = 1'b1;

    // Reference model: register contents as the software view sees them.
    logic [31:0] m_ctrl, m_load, m_cmp, m_val, m_rd;
    bit          m_match;
    int          m_pc;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %h, expected %h", nm, $time, act, exp);
        end
    endtask

    function automatic void model_reset();
        m_ctrl = 0; m_load = 0; m_cmp = 0; m_val = RST_VAL;
        m_rd = 0; m_match = 0; m_pc = 0;
    endfunction

    function automatic bit m_tick();
        return m_ctrl[0] && (m_pc == int'(m_ctrl[15:8]));
    endfunction

    function automatic bit m_irq();
`ifdef D_IP_TIMER_IRQ_EN
        return m_match && m_ctrl[2];
`else
        return 1'b0;
`endif
    endfunction

    // One clock: drive inputs on the falling edge, advance the model by the
    // rules for the coming rising edge, and queue the expected outputs.
    task automatic step(input bit we, input logic [1:0] wa, input logic [31:0] wd,
                        input bit re, input logic [1:0] ra);
        bit          tk, hit, nmatch;
        logic [31:0] nv;
        int          npc;
        exp_t        e;
        @(negedge clk);
        rst = rst_next; wr_en = we; wr_addr = wa; wr_data = wd; rd_en = re; rd_addr = ra;
        if (rst_next) begin
            model_reset();
        end else begin
            tk  = m_tick();
            hit = tk && (m_val == m_cmp);
            nv  = m_val;
            if (tk) nv = (hit && m_ctrl[1]) ? m_load : m_val + 32'd1;
            npc = (!m_ctrl[0] || tk) ? 0 : m_pc + 1;
            if (re) begin
                case (ra)
                    2'd0:    m_rd = m_ctrl;
                    2'd1:    m_rd = m_load;
                    2'd2:    m_rd = m_cmp;
                    default: m_rd = {31'b0, m_match};
                endcase
            end
            nmatch = m_match;
            if (we && wa == 2'd3 && wd[0]) nmatch = 1'b0;
            if (hit) nmatch = 1'b1;
            if (we) begin
                case (wa)
                    2'd0:    begin m_ctrl = wd & CTRL_MASK; npc = 0; end
                    2'd1:    begin m_load = wd; nv = wd; end
                    2'd2:    m_cmp = wd;
                    default: ;
                endcase
            end
            m_val = nv; m_pc = npc; m_match = nmatch;
        end
        e.v = m_val; e.irq = m_irq(); e.rd = m_rd;
        sb_q.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, 2'd0, 32'h0, 0, 2'd0);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        step(1, a, d, 0, 2'd0);
    endtask

    task automatic rd(input logic [1:0] a);
        step(0, 2'd0, 32'h0, 1, a);
    endtask

    // Reset asserted in the middle of a high clock phase must act at once.
    task automatic async_reset();
        @(posedge clk);
        #3;
        rst = 1'b1;
        rst_next = 1'b1;
        #1;
        chk("async_value", value, RST_VAL);
        chk("async_rd_data", rd_data, 32'h0);
        chk("async_irq", {31'b0, irq}, 32'h0);
        model_reset();
        idle(2);
        rst_next = 1'b0;
        idle(1);
    endtask

    // Monitor: compares whatever the driver predicted for this edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("value", value, e.v);
                chk("irq", {31'b0, irq}, {31'b0, e.irq});
                chk("rd_data", rd_data, e.rd);
            end
        end
    end

    initial begin
        bit done;
        model_reset();
        // Power-on reset, then first post-reset edge
        rst_next = 1'b1;
        idle(3);
        rst_next = 1'b0;
        idle(1);

        // Free run at PRESC=0
        wr(2'd1, 32'h0);
        wr(2'd0, 32'h1);
        idle(10);
        rd(2'd0);
        rd(2'd1);

        // Reset mid-count
        async_reset();
        idle(2);

        // Prescale by 4
        wr(2'd1, 32'd5);
        wr(2'd0, 32'h301);
        idle(14);
        rd(2'd0);

        // Auto-reload with interrupt enable (upper CTRL bits set to test masking)
        wr(2'd0, 32'h0);
        wr(2'd1, 32'd2);
        wr(2'd2, 32'd4);
        wr(2'd0, 32'hFFFF_0007);
        idle(8);
        rd(2'd3);
        rd(2'd0);
        wr(2'd3, 32'h0);
        wr(2'd3, 32'h1);
        rd(2'd3);
        // W1C landing on the match cycle: set must win
        done = 0;
        for (int i = 0; i < 10 && !done; i++) begin
            if (m_tick() && m_val == m_cmp) begin
                step(1, 2'd3, 32'h1, 1, 2'd3);
                done = 1;
            end else begin
                idle(1);
            end
        end
        rd(2'd3);
        idle(2);

        // Wrap through all-ones
        wr(2'd0, 32'h0);
        wr(2'd3, 32'h1);
        wr(2'd1, 32'hFFFF_FFFE);
        wr(2'd2, 32'h10);
        wr(2'd0, 32'h1);
        idle(22);
        rd(2'd3);

        // LOAD write colliding with a tick
        wr(2'd1, 32'h100);
        idle(3);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            bit          we, re;
            logic [1:0]  wa, ra;
            logic [31:0] wd;
            we = ($urandom_range(0, 99) < 30);
            re = ($urandom_range(0, 1) == 1);
            wa = 2'($urandom_range(0, 3));
            ra = 2'($urandom_range(0, 3));
            wd = $urandom;
            case (wa)
                2'd0: begin
                    if ($urandom_range(0, 1) == 1) wd[15:8] = 8'($urandom_range(0, 3));
                    wd[0] = ($urandom_range(0, 3) != 0);
                end
                2'd1: if ($urandom_range(0, 1) == 1) wd = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
                2'd2: wd = m_val + 32'($urandom_range(0, 6));
                default: ;
            endcase
            step(we, wa, wd, re, ra);
            if ($urandom_range(0, 499) == 0) async_reset();
        end
        idle(2);

        for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(posedge clk);
        #2;
        chk("scoreboard_drain", 32'(sb_q.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
